// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the single-cycle 8-bit CPU core.
//   - DATA_WIDTH / NUM_REGS: datapath width and register count
//   - opcode_e: instruction opcodes (undefined values execute as NOP)
//   - instruction field bit positions and flags_out bit indices
//   - helpers: immediate-operand decode, even parity
package cpu_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned NUM_REGS   = 16;
    localparam int unsigned REG_IDX_W  = 4;
    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned FLAG_W     = 5;

    // Instruction field positions
    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 24;
    localparam int unsigned RD_MSB  = 19;
    localparam int unsigned RD_LSB  = 16;
    localparam int unsigned RS1_MSB = 11;
    localparam int unsigned RS1_LSB = 8;
    localparam int unsigned RS2_MSB = 3;
    localparam int unsigned RS2_LSB = 0;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned IMM_LSB = 0;

    // flags_out = {overflow, carry, zero, sign, parity}
    localparam int unsigned FLAG_OVERFLOW = 4;
    localparam int unsigned FLAG_CARRY    = 3;
    localparam int unsigned FLAG_ZERO     = 2;
    localparam int unsigned FLAG_SIGN     = 1;
    localparam int unsigned FLAG_PARITY   = 0;

    typedef enum logic [7:0] {
        OpNop    = 8'h00,
        OpAdd    = 8'h01,
        OpSub    = 8'h02,
        OpAddImm = 8'h03,
        OpSubImm = 8'h04,
        OpAnd    = 8'h05,
        OpOr     = 8'h06,
        OpXor    = 8'h07,
        OpEql    = 8'h08,
        OpGrt    = 8'h09,
        OpLst    = 8'h0A,
        OpMul    = 8'h0B,
        OpOut    = 8'h0C
    } opcode_e;

    function automatic logic is_imm_op(input logic [7:0] op);
        return (op == OpAddImm) || (op == OpSubImm);
    endfunction

    // 1 when the value has an even number of set bits
    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] value);
        return ~^value;
    endfunction

endpackage

// File: rtl/cpu_if.sv
// cpu_if: fetch-side bus of the CPU core.
//   current_instruction : instruction executed at the next rising clock edge
//   cpu_output          : registered byte written by OUT
//   flags_out           : registered {overflow, carry, zero, sign, parity}
// master = fetch side / environment, slave = cpu_core.
interface cpu_if;
    import cpu_pkg::*;

    logic [INSTR_W-1:0]    current_instruction;
    logic [DATA_WIDTH-1:0] cpu_output;
    logic [FLAG_W-1:0]     flags_out;

    modport master (
        output current_instruction,
        input  cpu_output,
        input  flags_out
    );

    modport slave (
        input  current_instruction,
        output cpu_output,
        output flags_out
    );

endinterface

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU of the CPU core.
//   op       : opcode byte
//   a, b     : operands (b is already the immediate for *_IMM opcodes)
//   result   : value to write to rd
//   write_en : opcode writes a register (and therefore updates the flags)
//   flags    : {overflow, carry, zero, sign, parity} for result
// Build option: define CPU_MUL_EN to implement opcode 0B as signed multiply;
// without it 0B behaves as NOP and no multiplier exists.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [7:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  write_en,
    output logic [FLAG_W-1:0]     flags
);

    localparam int unsigned MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH:0] sum;
    logic [DATA_WIDTH:0] diff;
    logic                carry;
    logic                overflow;
`ifdef CPU_MUL_EN
    logic signed [2*DATA_WIDTH-1:0] product;
    logic                           product_ovf;

    assign product = $signed(a) * $signed(b);
    // Fits in signed 8 bits only if the top 9 bits are all copies of the sign
    assign product_ovf = !((&product[2*DATA_WIDTH-1:MSB]) || (~|product[2*DATA_WIDTH-1:MSB]));
`endif

    // Extra top bit: carry-out for add, borrow for subtract
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result   = '0;
        write_en = 1'b0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (op)
            OpAdd, OpAddImm: begin
                result   = sum[MSB:0];
                write_en = 1'b1;
                carry    = sum[DATA_WIDTH];
                overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OpSub, OpSubImm: begin
                result   = diff[MSB:0];
                write_en = 1'b1;
                carry    = diff[DATA_WIDTH];
                overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OpAnd: begin
                result   = a & b;
                write_en = 1'b1;
            end
            OpOr: begin
                result   = a | b;
                write_en = 1'b1;
            end
            OpXor: begin
                result   = a ^ b;
                write_en = 1'b1;
            end
            OpEql: begin
                result   = {{MSB{1'b0}}, a == b};
                write_en = 1'b1;
            end
            OpGrt: begin
                result   = {{MSB{1'b0}}, $signed(a) > $signed(b)};
                write_en = 1'b1;
            end
            OpLst: begin
                result   = {{MSB{1'b0}}, $signed(a) < $signed(b)};
                write_en = 1'b1;
            end
`ifdef CPU_MUL_EN
            OpMul: begin
                result   = product[MSB:0];
                write_en = 1'b1;
                carry    = product_ovf;
                overflow = product_ovf;
            end
`endif
            default: ;
        endcase

        flags                = '0;
        flags[FLAG_OVERFLOW] = overflow;
        flags[FLAG_CARRY]    = carry;
        flags[FLAG_ZERO]     = (result == '0);
        flags[FLAG_SIGN]     = result[MSB];
        flags[FLAG_PARITY]   = even_parity(result);
    end

endmodule

// File: rtl/cpu_core.sv
// cpu_core: single-cycle 8-bit CPU core (16 x 8-bit register file + ALU + flags).
//   clock_in   : system clock, all state updates on its rising edge
//   reset_n_in : asynchronous active-low reset; clears registers, cpu_output, flags_out
//   bus        : cpu_if.slave (current_instruction in; cpu_output, flags_out out)
// Build option: CPU_MUL_EN enables the MUL opcode inside cpu_alu.
module cpu_core
    import cpu_pkg::*;
(
    input logic  clock_in,
    input logic  reset_n_in,
    cpu_if.slave bus
);

    logic [7:0]            opcode;
    logic [REG_IDX_W-1:0]  rd_idx;
    logic [REG_IDX_W-1:0]  rs1_idx;
    logic [REG_IDX_W-1:0]  rs2_idx;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;
    logic [DATA_WIDTH-1:0] operand_b;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_write_en;
    logic [FLAG_W-1:0]     alu_flags;
    logic                  unused_fields;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] out_q;
    logic [FLAG_W-1:0]     flags_q;

    assign opcode  = bus.current_instruction[OPC_MSB:OPC_LSB];
    assign rd_idx  = bus.current_instruction[RD_MSB:RD_LSB];
    assign rs1_idx = bus.current_instruction[RS1_MSB:RS1_LSB];
    assign rs2_idx = bus.current_instruction[RS2_MSB:RS2_LSB];
    assign imm     = bus.current_instruction[IMM_MSB:IMM_LSB];

    // Reserved instruction bits are ignored
    assign unused_fields = ^{bus.current_instruction[23:20], bus.current_instruction[15:12]};

    // R0 is hardwired to zero; its storage is never written
    assign rs1_val   = (rs1_idx == '0) ? '0 : regs_q[rs1_idx];
    assign rs2_val   = (rs2_idx == '0) ? '0 : regs_q[rs2_idx];
    assign operand_b = is_imm_op(opcode) ? imm : rs2_val;

    cpu_alu u_alu (
        .op       (opcode),
        .a        (rs1_val),
        .b        (operand_b),
        .result   (alu_result),
        .write_en (alu_write_en),
        .flags    (alu_flags)
    );

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            // Flags follow every register-writing opcode, even when rd is R0
            if (alu_write_en) begin
                flags_q <= alu_flags;
                if (rd_idx != '0) begin
                    regs_q[rd_idx] <= alu_result;
                end
            end
            if (opcode == OpOut) begin
                out_q <= rs1_val;
            end
        end
    end

    assign bus.cpu_output = out_q;
    assign bus.flags_out  = flags_q;

endmodule

// File: tb/tb_cpu_core.sv
// Testbench for cpu_core: directed program with hand-computed expectations, then
// randomized instructions checked every cycle against a behavioural model.
module tb_cpu_core;
    import cpu_pkg::*;

    logic clock_in   = 1'b0;
    logic reset_n_in = 1'b0;

    cpu_if bus_if ();

    cpu_core dut (
        .clock_in   (clock_in),
        .reset_n_in (reset_n_in),
        .bus        (bus_if)
    );

    always #5 clock_in = ~clock_in;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [7:0] m_regs [16];
    logic [7:0] m_out;
    logic [4:0] m_flags;

    function automatic int to_s(input logic [7:0] v);
        return (int'(v) > 127) ? int'(v) - 256 : int'(v);
    endfunction

    function automatic logic [31:0] mk(input logic [7:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [7:0] lo);
        return {op, 4'h0, rd, 4'h0, rs1, lo};
    endfunction

    task automatic model_exec(input logic [31:0] ins);
        logic [7:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        int         full;
        int         sres;
        bit         wr;
        bit         c;
        bit         v;
        op   = ins[31:24];
        a    = m_regs[ins[11:8]];
        b    = (op == 8'h03 || op == 8'h04) ? ins[7:0] : m_regs[ins[3:0]];
        wr   = 1'b1;
        c    = 1'b0;
        v    = 1'b0;
        res  = '0;
        full = 0;
        sres = 0;
        case (op)
            8'h01, 8'h03: begin
                full = int'(a) + int'(b);
                sres = to_s(a) + to_s(b);
                c    = full > 255;
                v    = (sres > 127) || (sres < -128);
                res  = 8'(full);
            end
            8'h02, 8'h04: begin
                full = int'(a) - int'(b);
                sres = to_s(a) - to_s(b);
                c    = int'(a) < int'(b);
                v    = (sres > 127) || (sres < -128);
                res  = 8'(full);
            end
            8'h05: res = a & b;
            8'h06: res = a | b;
            8'h07: res = a ^ b;
            8'h08: res = (a == b) ? 8'd1 : 8'd0;
            8'h09: res = (to_s(a) > to_s(b)) ? 8'd1 : 8'd0;
            8'h0A: res = (to_s(a) < to_s(b)) ? 8'd1 : 8'd0;
`ifdef CPU_MUL_EN
            8'h0B: begin
                sres = to_s(a) * to_s(b);
                res  = 8'(sres);
                v    = (sres > 127) || (sres < -128);
                c    = v;
            end
`endif
            8'h0C: begin
                m_out = a;
                wr    = 1'b0;
            end
            default: wr = 1'b0;
        endcase
        if (wr) begin
            m_flags = {v, c, res == 8'd0, int'(res) >= 128, ($countones(res) % 2) == 0};
            if (ins[19:16] != 4'd0) m_regs[ins[19:16]] = res;
        end
    endtask

    always @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int i = 0; i < 16; i++) m_regs[i] = '0;
            m_out   = '0;
            m_flags = '0;
        end else begin
            model_exec(bus_if.current_instruction);
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clock_in) begin
        checks++;
        if (bus_if.cpu_output !== m_out) begin
            errors++;
            $display("FAIL cpu_output @%0t: got %h expected %h", $time, bus_if.cpu_output, m_out);
        end
        checks++;
        if (bus_if.flags_out !== m_flags) begin
            errors++;
            $display("FAIL flags_out @%0t: got %b expected %b", $time, bus_if.flags_out, m_flags);
        end
    end

    task automatic lit(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Checks DUT and model against the same hand-computed value
    task automatic lit2(input string name, input logic [7:0] dut_v, input logic [7:0] mdl_v,
                        input logic [7:0] want);
        lit(name, dut_v, want);
        lit({name, "_model"}, mdl_v, want);
    endtask

    task automatic issue(input logic [31:0] ins);
        @(negedge clock_in);
        bus_if.current_instruction = ins;
        @(posedge clock_in);
        #1;
    endtask

    task automatic chk_out(input string name, input logic [7:0] want);
        lit2(name, bus_if.cpu_output, m_out, want);
    endtask

    task automatic chk_flags(input string name, input logic [4:0] want);
        lit2(name, {3'b0, bus_if.flags_out}, {3'b0, m_flags}, {3'b0, want});
    endtask

    initial begin
        logic [7:0] op;
        bus_if.current_instruction = 32'h0;
        repeat (2) @(posedge clock_in);
        #1;
        chk_out("reset_out", 8'h00);
        chk_flags("reset_flags", 5'b00000);
        @(negedge clock_in);
        reset_n_in = 1'b1;

        issue(mk(OpAddImm, 1, 0, 8'd10));
        chk_flags("addi_r1", 5'b00001);
        issue(mk(OpAddImm, 2, 0, 8'd5));
        chk_flags("addi_r2", 5'b00001);
        issue(mk(OpAdd, 3, 1, 8'd2));
        chk_flags("add_r3", 5'b00001);
        issue(mk(OpSub, 4, 2, 8'd1));
        chk_flags("sub_r4", 5'b01010);
        issue(mk(OpOut, 0, 3, 8'd0));
        chk_out("out_r3", 8'd15);
        chk_flags("out_holds_flags", 5'b01010);
        issue(mk(OpOut, 0, 4, 8'd0));
        chk_out("out_r4", 8'hFB);

        issue(mk(OpAddImm, 5, 0, 8'd7));
        issue(mk(OpAddImm, 6, 0, 8'd7));
        issue(mk(OpEql, 7, 5, 8'd6));
        chk_flags("eql_flags", 5'b00000);
        issue(mk(OpOut, 0, 7, 8'd0));
        chk_out("eql_r7", 8'd1);

        issue(mk(OpAddImm, 8, 0, 8'd3));
        issue(mk(OpAddImm, 9, 0, 8'hFE));
        issue(mk(OpGrt, 10, 8, 8'd9));
        issue(mk(OpOut, 0, 10, 8'd0));
        chk_out("grt_signed", 8'd1);

        issue(mk(OpAddImm, 11, 0, 8'd127));
        issue(mk(OpAddImm, 12, 11, 8'd1));
        chk_flags("addi_ovf", 5'b10010);
        issue(mk(OpOut, 0, 12, 8'd0));
        chk_out("out_r12", 8'h80);
        issue(mk(OpSub, 13, 1, 8'd1));
        chk_flags("sub_zero", 5'b00101);

        issue(mk(OpAddImm, 0, 1, 8'd5));
        chk_flags("r0_write_flags", 5'b00001);
        issue(mk(OpOut, 0, 0, 8'd0));
        chk_out("r0_reads_zero", 8'd0);
        issue(32'h0);
        chk_flags("nop_holds", 5'b00001);
        issue(32'hFF00_0000);
        chk_flags("undef_holds", 5'b00001);

        issue(mk(OpMul, 14, 1, 8'd2));
`ifdef CPU_MUL_EN
        chk_flags("mul_flags", 5'b00000);
        issue(mk(OpOut, 0, 14, 8'd0));
        chk_out("mul_r14", 8'd50);
        issue(mk(OpMul, 15, 11, 8'd2));
        chk_flags("mul_ovf_flags", 5'b11001);
`else
        chk_flags("mul_nop_flags", 5'b00001);
        issue(mk(OpOut, 0, 14, 8'd0));
        chk_out("mul_nop_r14", 8'd0);
`endif

        // Randomized program; OUT is favoured so register contents stay visible
        for (int n = 0; n < 400; n++) begin
            op = 8'($urandom_range(0, 13));
            if ($urandom_range(0, 3) == 0) op = OpOut;
            if ($urandom_range(0, 15) == 0) op = 8'($urandom);
            issue(mk(op, 4'($urandom), 4'($urandom), 8'($urandom)));
        end

        // Asynchronous reset in the middle of a cycle
        issue(mk(OpAddImm, 1, 0, 8'h85));
        issue(mk(OpOut, 0, 1, 8'd0));
        chk_out("pre_reset_out", 8'h85);
        #2;
        reset_n_in = 1'b0;
        #1;
        chk_out("async_reset_out", 8'h00);
        chk_flags("async_reset_flags", 5'b00000);
        repeat (2) @(negedge clock_in);
        reset_n_in = 1'b1;
        issue(mk(OpOut, 0, 1, 8'd0));
        chk_out("post_reset_r1", 8'h00);
        for (int r = 2; r < 16; r++) issue(mk(OpOut, 0, 4'(r), 8'd0));
        issue(32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
